// File: rtl/clock_port_if.sv
// Clock-port bus front end: synchronises and glitch-filters the async host
// strobes and turns each accepted access into exactly one cmem read/write pulse.
module clock_port_if #(
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic       clk200,
  input  logic       reset_n,
  input  logic       CP_RD_n,
  input  logic       CP_WR_n,
  input  logic [3:0] CP_A,
  inout  wire  [3:0] CP_D,
  output logic       cp_read,
  output logic       cp_write,
  output logic [3:0] cp_address,
  output logic [3:0] cp_out_cmem_in,
  input  logic [3:0] cp_in_cmem_in,
  output logic       cp_busy
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_QUAL,
    WR_QUAL,
    RD_ISSUE,
    RD_DRIVE,
    WR_ISSUE,
    WR_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      rd_sync_q, wr_sync_q;
  logic [1:0][3:0] a_sync_q, d_sync_q;
  logic            rd_s, wr_s;
  logic [3:0]      a_s, d_s;
  logic            rd_arm_q, rd_arm_d;
  logic            wr_arm_q, wr_arm_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [3:0]      addr_q, addr_d;
  logic [3:0]      wdata_q, wdata_d;
  logic            drive_q, drive_d;
  logic            busy_q;

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      a_sync_q  <= '0;
      d_sync_q  <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[0], CP_RD_n};
      wr_sync_q <= {wr_sync_q[0], CP_WR_n};
      a_sync_q  <= {a_sync_q[0], CP_A};
      d_sync_q  <= {d_sync_q[0], CP_D};
    end
  end

  assign rd_s = rd_sync_q[1];
  assign wr_s = wr_sync_q[1];
  assign a_s  = a_sync_q[1];
  assign d_s  = d_sync_q[1];

  // A strobe is armed only once it has been seen high; an overlap disarms both,
  // so neither strobe can qualify until the host has released and re-asserted it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    drive_d  = drive_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    rd_arm_d = rd_arm_q;
    wr_arm_d = wr_arm_q;

    if (rd_s) begin
      rd_arm_d = 1'b1;
    end else if (!wr_s) begin
      rd_arm_d = 1'b0;
    end
    if (wr_s) begin
      wr_arm_d = 1'b1;
    end else if (!rd_s) begin
      wr_arm_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rd_s && wr_s && rd_arm_q) begin
          state_d = RD_QUAL;
          cnt_d   = 4'd1;
        end else if (!wr_s && rd_s && wr_arm_q) begin
          state_d = WR_QUAL;
          cnt_d   = 4'd1;
        end
      end
      RD_QUAL: begin
        if (rd_s || !wr_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RD_ISSUE;
          read_d  = 1'b1;
          addr_d  = a_s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_QUAL: begin
        if (wr_s || !rd_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WR_ISSUE;
          write_d = 1'b1;
          addr_d  = a_s;
          wdata_d = d_s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_DRIVE;
        drive_d = 1'b1;
      end
      RD_DRIVE: begin
        if (rd_s) begin
          state_d = IDLE;
          drive_d = 1'b0;
        end
      end
      WR_ISSUE: begin
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (wr_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_arm_q <= 1'b1;
      wr_arm_q <= 1'b1;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_arm_q <= rd_arm_d;
      wr_arm_q <= wr_arm_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      drive_q  <= drive_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign cp_read        = read_q;
  assign cp_write       = write_q;
  assign cp_address     = addr_q;
  assign cp_out_cmem_in = wdata_q;
  assign cp_busy        = busy_q;
  assign CP_D           = drive_q ? cp_in_cmem_in : 4'bzzzz;

endmodule

// File: tb/tb_clock_port_if.sv
// Directed bench for clock_port_if (FILTER_CYCLES=3): per-cycle vector table
// plus hand-written reset sequences. Undriven CP_D reads back as 4'hF.
module tb_clock_port_if;

  logic       clk200 = 1'b0;
  logic       reset_n;
  logic       CP_RD_n;
  logic       CP_WR_n;
  logic [3:0] CP_A;
  logic [3:0] cp_in_cmem_in;
  logic       tb_d_en;
  logic [3:0] tb_d;
  tri1  [3:0] CP_D;
  logic       cp_read;
  logic       cp_write;
  logic [3:0] cp_address;
  logic [3:0] cp_out_cmem_in;
  logic       cp_busy;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  assign CP_D = tb_d_en ? tb_d : 4'bzzzz;

  always #5 clk200 = ~clk200;

  clock_port_if #(.FILTER_CYCLES(3)) dut (
    .clk200         (clk200),
    .reset_n        (reset_n),
    .CP_RD_n        (CP_RD_n),
    .CP_WR_n        (CP_WR_n),
    .CP_A           (CP_A),
    .CP_D           (CP_D),
    .cp_read        (cp_read),
    .cp_write       (cp_write),
    .cp_address     (cp_address),
    .cp_out_cmem_in (cp_out_cmem_in),
    .cp_in_cmem_in  (cp_in_cmem_in),
    .cp_busy        (cp_busy)
  );

  typedef struct {
    logic       rd_n;
    logic       wr_n;
    logic       d_en;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] cmem;
    logic       e_rd;
    logic       e_wr;
    logic [3:0] e_addr;
    logic [3:0] e_wd;
    logic       e_busy;
    logic [3:0] e_bus;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] ea;
  logic [3:0] ew;

  task automatic add(input logic rd_n, input logic wr_n, input logic d_en,
                     input logic [3:0] a, input logic [3:0] d, input logic [3:0] cmem,
                     input logic e_rd, input logic e_wr, input logic e_busy,
                     input logic [3:0] e_bus);
    vec_t v;
    v.rd_n = rd_n;  v.wr_n = wr_n;  v.d_en = d_en;
    v.a = a;        v.d = d;        v.cmem = cmem;
    v.e_rd = e_rd;  v.e_wr = e_wr;  v.e_addr = ea;  v.e_wd = ew;
    v.e_busy = e_busy;  v.e_bus = e_bus;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [15:0] outs();
    return {1'b0, cp_read, cp_write, cp_address, cp_out_cmem_in, cp_busy, CP_D};
  endfunction

  always @(negedge clk200) begin
    if (reset_n === 1'b1 && !done) begin
      total++;
      if (cp_read && cp_write) begin
        bad++;
        $display("FAIL both_pulses: got rd=%b wr=%b want not both", cp_read, cp_write);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(1, 1, 0, 4'h0, 4'h0, 4'h5, 0, 0, 0, 4'hF);
  endtask

  initial begin
    int found;

    ea = 4'h0;
    ew = 4'h0;
    idle(2);
    // read: CP_A=A, data 5, strobe low 20 cycles; address changes after capture
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) ea = 4'hA;
      add(0, 1, 0, (k >= 6) ? 4'h3 : 4'hA, 4'h0, 4'h5, k == 5, 0, k >= 3, (k >= 6) ? 4'h5 : 4'hF);
    end
    for (int r = 1; r <= 3; r++) add(1, 1, 0, 4'h3, 4'h0, 4'h5, 0, 0, r < 3, (r < 3) ? 4'h5 : 4'hF);
    idle(2);
    // write: CP_A=B, CP_D=1, strobe low 10 cycles; a/d change after capture
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin ea = 4'hB; ew = 4'h1; end
      add(1, 0, 1, (k >= 6) ? 4'h7 : 4'hB, (k >= 6) ? 4'h9 : 4'h1, 4'h6,
          0, k == 5, k >= 3, (k >= 6) ? 4'h9 : 4'h1);
    end
    for (int r = 1; r <= 3; r++) add(1, 1, 0, 4'h7, 4'h0, 4'h6, 0, 0, r < 3, 4'hF);
    idle(2);
    // glitch: 2 low cycles -> no pulse
    for (int k = 1; k <= 5; k++) add((k <= 2) ? 1'b0 : 1'b1, 1, 0, 4'h4, 4'h0, 4'h5, 0, 0, k == 3 || k == 4, 4'hF);
    idle(2);
    // 3 low cycles -> exactly one pulse, one cycle of drive
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) ea = 4'hC;
      add((k <= 3) ? 1'b0 : 1'b1, 1, 0, 4'hC, 4'h0, 4'h5, k == 5, 0, k >= 3 && k <= 6, (k == 6) ? 4'h5 : 4'hF);
    end
    idle(2);
    // overlap, then WR released alone, then RD re-asserted
    for (int k = 1; k <= 10; k++) add(0, 0, 0, 4'hD, 4'h0, 4'h5, 0, 0, 0, 4'hF);
    for (int k = 1; k <= 6; k++)  add(0, 1, 0, 4'hD, 4'h0, 4'h5, 0, 0, 0, 4'hF);
    for (int k = 1; k <= 3; k++)  add(1, 1, 0, 4'hD, 4'h0, 4'h5, 0, 0, 0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) ea = 4'hD;
      add(0, 1, 0, 4'hD, 4'h0, 4'h5, k == 5, 0, k >= 3, (k >= 6) ? 4'h5 : 4'hF);
    end
    for (int r = 1; r <= 3; r++) add(1, 1, 0, 4'hD, 4'h0, 4'h5, 0, 0, r < 3, (r < 3) ? 4'h5 : 4'hF);
    idle(2);
    // long write strobe: 1000 cycles, one pulse
    for (int k = 1; k <= 1000; k++) begin
      if (k == 5) begin ea = 4'hE; ew = 4'h2; end
      add(1, 0, 1, 4'hE, 4'h2, 4'h5, 0, k == 5, k >= 3, 4'h2);
    end
    for (int r = 1; r <= 3; r++) add(1, 1, 0, 4'hE, 4'h0, 4'h5, 0, 0, r < 3, 4'hF);
    idle(2);
    // back-to-back writes, 4-cycle gap, addresses 0 then 1
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin ea = 4'h0; ew = 4'h3; end
      add(1, 0, 1, 4'h0, 4'h3, 4'h5, 0, k == 5, k >= 3, 4'h3);
    end
    for (int r = 1; r <= 4; r++) add(1, 1, 0, 4'h0, 4'h0, 4'h5, 0, 0, r < 3, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin ea = 4'h1; ew = 4'h4; end
      add(1, 0, 1, 4'h1, 4'h4, 4'h5, 0, k == 5, k >= 3, 4'h4);
    end
    for (int r = 1; r <= 3; r++) add(1, 1, 0, 4'h1, 4'h0, 4'h5, 0, 0, r < 3, 4'hF);
    idle(2);

    reset_n = 1'b0;
    CP_RD_n = 1'b1;
    CP_WR_n = 1'b1;
    CP_A = 4'h0;
    cp_in_cmem_in = 4'h5;
    tb_d_en = 1'b0;
    tb_d = 4'h0;
    #2;
    check("reset_state", outs(), {1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hF});
    repeat (2) @(negedge clk200);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk200);
      CP_RD_n = vecs[i].rd_n;
      CP_WR_n = vecs[i].wr_n;
      CP_A = vecs[i].a;
      tb_d = vecs[i].d;
      tb_d_en = vecs[i].d_en;
      cp_in_cmem_in = vecs[i].cmem;
      @(posedge clk200);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {1'b0, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wd,
             vecs[i].e_busy, vecs[i].e_bus});
    end

    // reset in the middle of a read drive phase
    @(negedge clk200);
    CP_A = 4'h6;
    cp_in_cmem_in = 4'h9;
    CP_RD_n = 1'b0;
    repeat (7) @(posedge clk200);
    #1;
    check("drive_before_reset", {12'h0, CP_D}, {12'h0, 4'h9});
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_drive", outs(), {1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hF});
    repeat (2) @(negedge clk200);
    reset_n = 1'b1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk200);
      #1;
      if (cp_read && found == 0) found = k;
    end
    check("requal_latency", 16'(found), 16'd5);
    check("requal_addr", {12'h0, cp_address}, {12'h0, 4'h6});
    @(negedge clk200);
    CP_RD_n = 1'b1;
    repeat (4) @(posedge clk200);
    #1;
    check("final_release", {14'h0, cp_busy, 1'b0} | {12'h0, CP_D}, {12'h0, 4'hF});

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
